// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared constants and FSM state type for the interrupt path
package interrupt_controller_pkg;

    typedef enum bit [1:0] {IC_IDLE, IC_REQUEST, IC_IN_SERVICE} IntCtrlState;

    localparam int INT_SOURCES       = 8;
    localparam int INT_VECTOR_BITS   = 3;
    localparam int INT_LOST_CNT_BITS = 8;

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: request/acknowledge/end-of-interrupt handshake to exec_unit
interface interrupt_controller_if #(
    parameter int VECTOR_BITS = 3
);

    logic                   int_req;
    logic                   int_ack;
    logic                   eoi;
    logic [VECTOR_BITS-1:0] int_vector;

    modport master (output int_req, output int_vector, input int_ack, input eoi);
    modport slave  (input int_req, input int_vector, output int_ack, output eoi);

endinterface

// File: rtl/interrupt_controller_irq_edge_sync.sv
// irq_edge_sync: two-flop synchroniser plus history flop, emits one-cycle rising-edge pulses
module irq_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] s0_q, s1_q, h_q;

    // s0/s1 resolve metastability; h remembers the previous synchronised level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q <= '0;
            s1_q <= '0;
            h_q  <= '0;
        end else begin
            s0_q <= async_i;
            s1_q <= s0_q;
            h_q  <= s1_q;
        end
    end

    assign rise_o = s1_q & ~h_q;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, maskable, fixed-priority interrupt requester for exec_unit
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SOURCES   = INT_SOURCES,
    parameter int VECTOR_BITS   = INT_VECTOR_BITS,
    parameter int LOST_CNT_BITS = INT_LOST_CNT_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SOURCES-1:0]   irq_in,
    input  logic                     mask_wr_en,
    input  logic [NUM_SOURCES-1:0]   mask_wr_data,
    output logic [NUM_SOURCES-1:0]   mask,
    output logic [NUM_SOURCES-1:0]   pending,
    output logic [LOST_CNT_BITS-1:0] lost_count,
    interrupt_controller_if.master   irq_bus
);

    localparam int SUMW = LOST_CNT_BITS + VECTOR_BITS + 1;

    logic [NUM_SOURCES-1:0]   rise, active, clr, lost_hits;
    logic [NUM_SOURCES-1:0]   mask_q, mask_d, pend_q, pend_d;
    logic [LOST_CNT_BITS-1:0] lost_q, lost_d;
    logic [SUMW-1:0]          lost_sum;
    logic [VECTOR_BITS-1:0]   vec_q, vec_d;
    logic                     req_q, req_d;
    IntCtrlState              state_q, state_d;

    function automatic logic [VECTOR_BITS-1:0] prio_enc(input logic [NUM_SOURCES-1:0] v);
        prio_enc = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--)
            if (v[i]) prio_enc = VECTOR_BITS'(i);
    endfunction

    irq_edge_sync #(.WIDTH(NUM_SOURCES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (irq_in),
        .rise_o  (rise)
    );

    // pending/mask/lost-count next state; a new edge beats the acknowledge clear on the same bit
    always_comb begin
        active    = pend_q & mask_q;
        clr       = (state_q == IC_REQUEST && irq_bus.int_ack) ? NUM_SOURCES'(1) << vec_q : '0;
        lost_hits = rise & pend_q & ~clr;
        lost_sum  = SUMW'(lost_q) + SUMW'($countones(lost_hits));
        lost_d    = |lost_sum[SUMW-1:LOST_CNT_BITS] ? '1 : lost_sum[LOST_CNT_BITS-1:0];
        pend_d    = (pend_q & ~clr) | rise;
        mask_d    = mask_wr_en ? mask_wr_data : mask_q;
    end

    // request FSM; the vector is captured only when leaving idle so it stays stable through service
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        case (state_q)
            IC_IDLE: if (|active) begin
                state_d = IC_REQUEST;
                req_d   = 1'b1;
                vec_d   = prio_enc(active);
            end
            IC_REQUEST: if (irq_bus.int_ack) begin
                state_d = IC_IN_SERVICE;
                req_d   = 1'b0;
            end
            IC_IN_SERVICE: if (irq_bus.eoi) state_d = IC_IDLE;
            default: begin
                state_d = IC_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // all state clears immediately on reset so a pending request is dropped at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            pend_q  <= '0;
            lost_q  <= '0;
            vec_q   <= '0;
            req_q   <= 1'b0;
            state_q <= IC_IDLE;
        end else begin
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            vec_q   <= vec_d;
            req_q   <= req_d;
            state_q <= state_d;
        end
    end

    assign mask               = mask_q;
    assign pending            = pend_q;
    assign lost_count         = lost_q;
    assign irq_bus.int_req    = req_q;
    assign irq_bus.int_vector = vec_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed plan plus random traffic against a cycle-level reference model
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       mask_wr_en;
    logic [7:0] mask_wr_data;
    logic [7:0] mask, pending, lost_count;

    interrupt_controller_if #(.VECTOR_BITS(3)) bus ();

    interrupt_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq_in       (irq_in),
        .mask_wr_en   (mask_wr_en),
        .mask_wr_data (mask_wr_data),
        .mask         (mask),
        .pending      (pending),
        .lost_count   (lost_count),
        .irq_bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_pend, m_mask;
    logic       m_req;
    int         m_vec, m_lost, m_phase;
    logic [7:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_req = 0; m_vec = 0; m_lost = 0; m_phase = 0;
        hist = '{8'h00, 8'h00, 8'h00};
    endtask

    // hist[k] is irq_in as sampled k+1 edges ago; an edge reaches pending two edges after first sampling
    task automatic model_edge();
        logic [7:0] rise, clr, act;
        int hits;
        rise = hist[1] & ~hist[2];
        clr = (m_phase == 1 && bus.int_ack) ? 8'(1) << m_vec : 8'h00;
        hits = $countones(rise & m_pend & ~clr);
        m_lost = (m_lost + hits > 255) ? 255 : m_lost + hits;
        act = m_pend & m_mask;
        if (m_phase == 0 && act != 0) begin
            m_phase = 1; m_req = 1; m_vec = $clog2(int'(act & (~act + 8'd1)));
        end else if (m_phase == 1 && bus.int_ack) begin
            m_phase = 2; m_req = 0;
        end else if (m_phase == 2 && bus.eoi) begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (mask_wr_en) m_mask = mask_wr_data;
        hist.push_front(irq_in);
        void'(hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("mask", mask, m_mask);
        chk("pending", pending, m_pend);
        chk("int_req", bus.int_req, m_req);
        chk("int_vector", bus.int_vector, m_vec);
        chk("lost_count", lost_count, m_lost);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.int_req && n < 50) begin
            tick();
            n++;
        end
        chk("req_wait", bus.int_req, 1);
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_wr_en = 1; mask_wr_data = v;
        tick();
        mask_wr_en = 0;
    endtask

    task automatic ack_then_eoi();
        bus.int_ack = 1; tick(); bus.int_ack = 0;
        bus.eoi = 1; tick(); bus.eoi = 0;
    endtask

    initial begin
        reset_n = 0; irq_in = 0; mask_wr_en = 0; mask_wr_data = 0;
        bus.int_ack = 0; bus.eoi = 0;
        model_reset();
        @(negedge clk);
        chk("rst_mask", mask, 0);
        chk("rst_pending", pending, 0);
        chk("rst_req", bus.int_req, 0);
        chk("rst_vector", bus.int_vector, 0);
        chk("rst_lost", lost_count, 0);
        @(negedge clk);
        reset_n = 1;

        // 1: single source, latency and handshake
        write_mask(8'hFF);
        irq_in = 8'h20;
        ticks(3);
        chk("t1_pend_e2", pending, 8'h20);
        chk("t1_req_e2", bus.int_req, 0);
        irq_in = 0;
        tick();
        chk("t1_req_e3", bus.int_req, 1);
        chk("t1_vec", bus.int_vector, 5);
        ticks(3);
        chk("t1_req_hold", bus.int_req, 1);
        bus.int_ack = 1; tick(); bus.int_ack = 0;
        chk("t1_req_drop", bus.int_req, 0);
        chk("t1_pend_clr", pending, 0);
        bus.eoi = 1; tick(); bus.eoi = 0;

        // 2: simultaneous sources, priority and back-to-back gap
        irq_in = 8'h44;
        ticks(4);
        irq_in = 0;
        chk("t2_vec_first", bus.int_vector, 2);
        bus.int_ack = 1; tick(); bus.int_ack = 0;
        bus.eoi = 1; tick(); bus.eoi = 0;
        chk("t2_gap", bus.int_req, 0);
        tick();
        chk("t2_rereq", bus.int_req, 1);
        chk("t2_vec_second", bus.int_vector, 6);
        ack_then_eoi();

        // 3: masked pending bit, serviced once unmasked
        write_mask(8'h00);
        irq_in = 8'h08;
        ticks(3);
        irq_in = 0;
        ticks(3);
        chk("t3_pend", pending, 8'h08);
        chk("t3_noreq", bus.int_req, 0);
        write_mask(8'h08);
        chk("t3_req_wait", bus.int_req, 0);
        tick();
        chk("t3_req", bus.int_req, 1);
        chk("t3_vec", bus.int_vector, 3);
        ack_then_eoi();
        write_mask(8'hFF);

        // 4: lost edges and saturation
        irq_in = 8'h01;
        ticks(3);
        for (int i = 0; i < 3; i++) begin
            irq_in = 0; tick();
            irq_in = 1; tick();
        end
        irq_in = 0;
        ticks(3);
        chk("t4_lost3", lost_count, 3);
        chk("t4_pend0", pending[0], 1);
        for (int i = 0; i < 300; i++) begin
            irq_in = 1; tick();
            irq_in = 0; tick();
        end
        ticks(3);
        chk("t4_sat", lost_count, 8'hFF);
        ack_then_eoi();

        // 5: new edge collides with the acknowledge clear
        irq_in = 8'h10;
        ticks(3);
        irq_in = 0;
        tick();
        chk("t5_vec", bus.int_vector, 4);
        irq_in = 8'h10;
        ticks(2);
        bus.int_ack = 1; tick(); bus.int_ack = 0;
        irq_in = 0;
        chk("t5_pend_kept", pending[4], 1);
        chk("t5_req_drop", bus.int_req, 0);
        bus.eoi = 1; tick(); bus.eoi = 0;
        tick();
        chk("t5_rereq", bus.int_req, 1);
        chk("t5_vec2", bus.int_vector, 4);
        ack_then_eoi();

        // 6: asynchronous reset in the middle of a request
        irq_in = 8'h80;
        ticks(4);
        irq_in = 0;
        chk("t6_inreq", bus.int_req, 1);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("t6_req_async", bus.int_req, 0);
        chk("t6_pend_async", pending, 0);
        chk("t6_vec_async", bus.int_vector, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        write_mask(8'hFF);
        ticks(5);
        chk("t6_noreq", bus.int_req, 0);
        irq_in = 8'h02;
        wait_req();
        chk("t6_vec", bus.int_vector, 1);
        irq_in = 0;
        ack_then_eoi();

        // random traffic: sparse toggles, stray ack/eoi, occasional mask writes
        for (int i = 0; i < 1500; i++) begin
            irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            bus.int_ack = ($urandom_range(0, 3) == 0);
            bus.eoi = ($urandom_range(0, 4) == 0);
            mask_wr_en = ($urandom_range(0, 15) == 0);
            mask_wr_data = 8'($urandom);
            tick();
        end
        bus.int_ack = 0; bus.eoi = 0; mask_wr_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
